// File: rtl/matrix_operand_loader_if.sv
// ============================================================================
// Module      : matrix_operand_loader_if
// Description : Element-stream input and packed-operand output bundle of the
//               2x2 matrix multiplier operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_operand_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_sof;
  logic                in_ready;
  logic [4*DATA_W-1:0] a_out;
  logic [4*DATA_W-1:0] b_out;
  logic                out_valid;
  logic                out_ready;
  logic                frame_err;

  // Producer of elements / consumer of operand pairs
  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, a_out, b_out, out_valid, frame_err
  );

  // The loader itself
  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, a_out, b_out, out_valid, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/matrix_operand_loader.sv
// ============================================================================
// Module      : matrix_operand_loader
// Description : Collects an 8-element frame (A00..A11, B00..B11) into packed
//               32-bit operands A and B, presents them with valid/ready, and
//               flags missing/mid-frame start-of-frame and idle timeouts.
//               Optional: define MATLOAD_TRANSPOSE_B_EN to store B transposed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_operand_loader #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input wire logic              clk,
  input wire logic              rst,
  matrix_operand_loader_if.slave bus
);

  localparam int C_TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST =
    C_TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_A  = 2'd1,
    S_LOAD_B  = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t              r_state;
  logic [3:0]          r_elem_cnt;
  logic [C_TO_W-1:0]   r_to_cnt;
  logic [4*DATA_W-1:0] r_a;
  logic [4*DATA_W-1:0] r_b;
  logic                r_out_valid;
  logic                r_frame_err;

  logic                w_in_ready;
  logic                w_accept;
  logic [1:0]          w_a_pos;
  logic [1:0]          w_b_slot;
  logic [1:0]          w_b_pos;

  assign w_in_ready = (r_state != S_PRESENT);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Slot positions count from the MSB end: element 0 lands in the top byte.
  assign w_a_pos = 2'd3 - r_elem_cnt[1:0];

`ifdef MATLOAD_TRANSPOSE_B_EN
  // Stream order B00,B01,B10,B11 is stored as B00,B10,B01,B11 (row/col swap).
  assign w_b_slot = {r_elem_cnt[0], r_elem_cnt[1]};
`else
  assign w_b_slot = r_elem_cnt[1:0];
`endif
  assign w_b_pos = 2'd3 - w_b_slot;

  // Frame assembly state machine with timeout and framing-error detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_elem_cnt  <= 4'd0;
      r_to_cnt    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_accept) begin
            if (bus.in_sof) begin
              r_a[4*DATA_W-1 -: DATA_W] <= bus.in_data;
              r_elem_cnt                <= 4'd1;
              r_state                   <= S_LOAD_A;
            end else begin
              // Element without a frame start is dropped.
              r_frame_err <= 1'b1;
            end
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          if (w_accept) begin
            r_to_cnt <= '0;
            if (bus.in_sof) begin
              // A new frame start overrides the partial one.
              r_frame_err               <= 1'b1;
              r_a[4*DATA_W-1 -: DATA_W] <= bus.in_data;
              r_elem_cnt                <= 4'd1;
              r_state                   <= S_LOAD_A;
            end else if (r_state == S_LOAD_A) begin
              r_a[w_a_pos*DATA_W +: DATA_W] <= bus.in_data;
              r_elem_cnt                    <= r_elem_cnt + 4'd1;
              if (r_elem_cnt == 4'd3) begin
                r_state <= S_LOAD_B;
              end
            end else begin
              r_b[w_b_pos*DATA_W +: DATA_W] <= bus.in_data;
              r_elem_cnt                    <= r_elem_cnt + 4'd1;
              if (r_elem_cnt == 4'd7) begin
                r_state     <= S_PRESENT;
                r_out_valid <= 1'b1;
              end
            end
          end else if (TIMEOUT_CYC != 0) begin
            if (r_to_cnt == C_TO_LAST) begin
              // Partial operand contents are left as-is.
              r_frame_err <= 1'b1;
              r_elem_cnt  <= 4'd0;
              r_to_cnt    <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end

        S_PRESENT: begin
          r_to_cnt <= '0;
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_elem_cnt  <= 4'd0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.out_valid = r_out_valid;
  assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
// ============================================================================
// Module      : tb_matrix_operand_loader
// Description : Self-checking bench for matrix_operand_loader (TIMEOUT_CYC=4).
//               Honours MATLOAD_TRANSPOSE_B_EN for the expected B packing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_operand_loader;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  matrix_operand_loader_if #(.DATA_W(8)) bus ();

  matrix_operand_loader #(.DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of received bytes; a pair is produced
  // once eight bytes started by an sof have arrived.
  logic [7:0]  m_frame[$];
  bit          m_present;
  int          m_idle;
  bit          m_err;
  logic [31:0] m_a;
  logic [31:0] m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_frame.delete();
      m_present = 0;
      m_idle    = 0;
      m_err     = 0;
      m_a       = '0;
      m_b       = '0;
    end else begin
      m_err = 0;
      if (m_present) begin
        if (bus.out_ready) m_present = 0;
      end else if (bus.in_valid) begin
        m_idle = 0;
        if (bus.in_sof) begin
          if (m_frame.size() != 0) m_err = 1;
          m_frame.delete();
          m_frame.push_back(bus.in_data);
        end else if (m_frame.size() == 0) begin
          m_err = 1;
        end else begin
          m_frame.push_back(bus.in_data);
          if (m_frame.size() == 8) begin
            m_a = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
`ifdef MATLOAD_TRANSPOSE_B_EN
            m_b = {m_frame[4], m_frame[6], m_frame[5], m_frame[7]};
`else
            m_b = {m_frame[4], m_frame[5], m_frame[6], m_frame[7]};
`endif
            m_present = 1;
            m_frame.delete();
          end
        end
      end else if (m_frame.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err  = 1;
          m_idle = 0;
          m_frame.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model plus event bookkeeping
  int          ov_cycles = 0;
  int          err_seen  = 0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, !m_present});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_present});
      chk("frame_err", {31'd0, bus.frame_err}, {31'd0, m_err});
      if (m_present) begin
        chk("a_out", bus.a_out, m_a);
        chk("b_out", bus.b_out, m_b);
      end
      if (bus.out_valid) begin
        ov_cycles++;
        last_a = bus.a_out;
        last_b = bus.b_out;
      end
      if (bus.frame_err) err_seen++;
    end
  end

  task automatic send(input logic [7:0] d, input logic sof);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  // Sends a full frame whose bytes are base+1 .. base+8
  task automatic send_frame(input logic [7:0] base);
    for (int i = 1; i <= 8; i++) begin
      send(base + 8'(i), (i == 1));
    end
  endtask

  int e0;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_a_out",     bus.a_out, 32'h0);
    chk("rst_b_out",     bus.b_out, 32'h0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    #11;
    rst = 1'b0;
    idle(2);

    // Normal frame
    ov_cycles = 0;
    send_frame(8'h00);
    idle(3);
    chk("norm_ov_cycles", ov_cycles, 1);
    chk("norm_a", last_a, 32'h01020304);
`ifdef MATLOAD_TRANSPOSE_B_EN
    chk("norm_b", last_b, 32'h05070608);
`else
    chk("norm_b", last_b, 32'h05060708);
`endif

    // Backpressure
    ov_cycles     = 0;
    bus.out_ready = 1'b0;
    send_frame(8'h00);
    idle(10);
    chk("bp_in_ready_held", {31'd0, bus.in_ready},  32'd0);
    chk("bp_valid_held",    {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    idle(3);
    chk("bp_ov_cycles", ov_cycles, 10);
    chk("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_a", last_a, 32'h01020304);

    // Missing sof
    e0 = err_seen;
    send(8'hAA, 1'b0);
    send_frame(8'h10);
    idle(3);
    chk("nosof_err_pulses", err_seen - e0, 1);
    chk("nosof_a", last_a, 32'h11121314);
`ifdef MATLOAD_TRANSPOSE_B_EN
    chk("nosof_b", last_b, 32'h15171618);
`else
    chk("nosof_b", last_b, 32'h15161718);
`endif

    // Mid-frame sof
    e0 = err_seen;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send_frame(8'h20);
    idle(3);
    chk("midsof_err_pulses", err_seen - e0, 1);
    chk("midsof_a", last_a, 32'h21222324);
`ifdef MATLOAD_TRANSPOSE_B_EN
    chk("midsof_b", last_b, 32'h25272628);
`else
    chk("midsof_b", last_b, 32'h25262728);
`endif

    // Timeout
    e0        = err_seen;
    ov_cycles = 0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    idle(8);
    chk("to_err_pulses", err_seen - e0, 1);
    chk("to_no_valid", ov_cycles, 0);
    chk("to_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Asynchronous reset in LOAD_B
    for (int i = 1; i <= 6; i++) send(8'(i), (i == 1));
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_a_out", bus.a_out, 32'h0);
    chk("arst_b_out", bus.b_out, 32'h0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    idle(1);
    ov_cycles = 0;
    send_frame(8'h00);
    idle(3);
    chk("arst_ov_cycles", ov_cycles, 1);
    chk("arst_a", last_a, 32'h01020304);
`ifdef MATLOAD_TRANSPOSE_B_EN
    chk("arst_b", last_b, 32'h05070608);
`else
    chk("arst_b", last_b, 32'h05060708);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream stage of the 2x2 matrix multiplier.
- Receives a stream of 8-bit matrix elements, one per handshake.
- Assembles operand A then operand B into 32-bit packed words and presents them to the multiplier with a valid/ready handshake.
- Holds the outputs stable until the multiplier consumes them.
- Detects framing errors and inter-element timeouts.

Parameters:
- DATA_W, 8, width of one matrix element; packed operand width is 4*DATA_W.
- TIMEOUT_CYC, 64, maximum idle cycles between elements inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  DATA_W  element byte.
- in_valid  in  1  in_data valid.
- in_sof  in  1  marks the first element (A[0][0]) of a frame; qualified by in_valid.
- in_ready  out  1  loader can accept an element.
- a_out  out  4*DATA_W  packed A = {A00,A01,A10,A11}; A00 in the MSBs.
- b_out  out  4*DATA_W  packed B, same packing.
- out_valid  out  1  a_out/b_out hold a complete operand pair.
- out_ready  in  1  multiplier accepts the pair.
- frame_err  out  1  one-cycle pulse on any framing or timeout abort.

Behaviour:
- Reset (async, rst=1): state=IDLE, elem_cnt=0, a_out=0, b_out=0, out_valid=0, frame_err=0, timeout counter=0. in_ready follows state, so it is 1 in IDLE.
- Element acceptance: an element is accepted on a rising edge with in_valid&in_ready.
- Frame format: 8 accepted elements in order A00,A01,A10,A11,B00,B01,B10,B11. The first carries in_sof=1; all others carry in_sof=0.
- States:
  - IDLE: in_ready=1. An accepted element with sof=1 is written to A00, elem_cnt=1, next state LOAD_A. An accepted element with sof=0 is dropped and frame_err pulses; state stays IDLE.
  - LOAD_A: in_ready=1. Accepted elements fill A01,A10,A11. After A11 is written (elem_cnt reaches 4), go to LOAD_B.
  - LOAD_B: in_ready=1. Accepted elements fill B00..B11. On the B11 write, go to PRESENT and set out_valid=1 on the same edge.
  - PRESENT: in_ready=0; a_out/b_out are stable.
    - On out_valid&out_ready: out_valid=0, elem_cnt=0, go to IDLE.
    - The next frame's first element can be accepted no earlier than the cycle after the handshake (in_ready=1 in IDLE).
- Mid-frame sof (LOAD_A/LOAD_B, accepted element with sof=1):
  - Abort the current frame and pulse frame_err.
  - Treat the element as a new A00: write A00, elem_cnt=1, state LOAD_A.
- Timeout: in LOAD_A/LOAD_B, a counter increments each cycle with no accepted element and clears on every accept.
  - On reaching TIMEOUT_CYC (when nonzero): pulse frame_err, elem_cnt=0, state IDLE.
  - Partially written operand registers are not cleared.
  - The counter is inactive in IDLE and PRESENT.
- a_out/b_out are registered and update only on element writes. Output latency is 1 cycle from the B11 accept to out_valid=1.
- frame_err is registered, high for exactly one cycle per event.
- rst asserted mid-frame or in PRESENT gives immediate return to reset values; any in-flight pair is lost.

Optional Feature:
- Macro MATLOAD_TRANSPOSE_B_EN.
- Defined: the B elements are stored transposed. Stream order B00,B01,B10,B11 lands in positions B00,B10,B01,B11, so b_out = {e4,e6,e5,e7} for stream elements e4..e7.
- Not defined: straight packing, b_out = {e4,e5,e6,e7}.
- A packing and all timing are identical either way.

Test Plan:
- Normal frame: stream 01,02,03,04,05,06,07,08 (sof on 01), out_ready=1. Required: a_out=32'h01020304, b_out=32'h05060708, out_valid high exactly 1 cycle, starting the cycle after the 08 accept.
- Backpressure: same frame with out_ready=0 for 10 cycles. Required: out_valid and outputs held, in_ready=0 throughout; after out_ready=1, one handshake, then in_ready=1 next cycle.
- Missing sof: first element 0xAA sent with sof=0. Required: frame_err pulses once, state stays IDLE; a following correct frame 11..18 gives a_out=32'h11121314, b_out=32'h15161718.
- Mid-frame sof: send 01,02,03 then 0x21 with sof, then 22..28. Required: one frame_err pulse; outputs a_out=32'h21222324, b_out=32'h25262728.
- Timeout (TIMEOUT_CYC=4): send 01,02 then hold in_valid=0 for 4 cycles. Required: frame_err pulse on the 4th idle cycle, return to IDLE, out_valid never asserted.
- Async reset during LOAD_B (after 6 elements): pulse rst mid-cycle. Required: out_valid=0, a_out=b_out=0 immediately, in_ready=1; with MATLOAD_TRANSPOSE_B_EN a full frame 01..08 gives b_out=32'h05070608.
